// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg
//   Shared constants and the flush FSM state encoding for fifo_byte_packer
//   and its output slot.
package fifo_pack_pkg;

    localparam int DEF_WIDTH = 8;   // FIFO entry width
    localparam int DEF_PACK  = 4;   // entries per packed output word

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH_EMIT = 2'd2
    } pack_state_e;

endpackage

// File: rtl/stream_out_slot.sv
// stream_out_slot
//   Single-entry valid/ready output register. The owner loads a word only
//   when slot_free is high; the word then sits stable until accepted.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   load          load load_data/load_keep this edge (only while slot_free)
//   load_data     word to present, lane 0 = oldest entry
//   load_keep     lane valid mask for load_data
//   m_data/m_keep/m_valid/m_ready   output stream
//   slot_free     slot empty or draining this cycle
module stream_out_slot
    import fifo_pack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PACK  = DEF_PACK
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [PACK-1:0][WIDTH-1:0]  load_data,
    input  logic [PACK-1:0]             load_keep,
    output logic [WIDTH*PACK-1:0]       m_data,
    output logic [PACK-1:0]             m_keep,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        slot_free
);

    assign slot_free = !m_valid || m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_keep  <= load_keep;
        end else if (m_valid && m_ready) begin
            // data/keep keep their last value; only valid drops
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_byte_packer.sv
// fifo_byte_packer
//   Drains WIDTH-bit entries from a synchronous FIFO (one-cycle read
//   latency) and packs PACK of them into one WIDTH*PACK-bit stream word.
//   A flush request emits the partial word with a lane keep mask.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   fifo_empty/fifo_dout FIFO status and read data (valid cycle after rd_en)
//   fifo_rd_en           FIFO read strobe
//   flush / flush_done   partial-word request / one-cycle completion pulse
//   m_data/m_keep/m_valid/m_ready   packed output stream
//   busy                 anything in flight or FSM not idle
module fifo_byte_packer
    import fifo_pack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PACK  = DEF_PACK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [WIDTH-1:0]      fifo_dout,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]       m_keep,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int CW = $clog2(PACK + 1);

    typedef logic [PACK-1:0][WIDTH-1:0] word_t;

    pack_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          rd_pend_q;
    word_t         asm_q;
    logic          flush_done_q, flush_done_d;

    logic          slot_free;
    logic          cnt_is_last, cnt_is_full, cnt_is_zero;
    logic [CW:0]   inflight;
    logic          load_full, load_part, load;
    word_t         full_word, part_word, load_word;
    logic [PACK-1:0] part_keep, load_keep;

    assign cnt_is_last = (cnt_q == CW'(PACK - 1));
    assign cnt_is_full = (cnt_q == CW'(PACK));
    assign cnt_is_zero = (cnt_q == '0);

    // Entries captured plus the one in flight must not exceed a word, so a
    // blocked output slot naturally stalls FIFO reads.
    assign inflight   = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q};
    assign fifo_rd_en = !fifo_empty && (state_q == FILL) &&
                        (inflight < (CW+1)'(PACK));

    // Full word: either completed by this cycle's capture, or already held
    // (cnt==PACK) waiting for the slot. Partial word only from FLUSH_EMIT,
    // where rd_pend is 0 and cnt is 1..PACK-1, so the two never collide.
    assign load_full = slot_free && ((rd_pend_q && cnt_is_last) || cnt_is_full);
    assign load_part = slot_free && (state_q == FLUSH_EMIT);
    assign load      = load_full || load_part;
    assign load_word = load_full ? full_word : part_word;
    assign load_keep = load_full ? {PACK{1'b1}} : part_keep;

    for (genvar i = 0; i < PACK; i++) begin : g_lane
        if (i == PACK - 1) begin : g_top
            // top lane bypasses the assembly register when completing now
            assign full_word[i] = rd_pend_q ? fifo_dout : asm_q[i];
        end else begin : g_low
            assign full_word[i] = asm_q[i];
        end
        assign part_keep[i] = (cnt_q > CW'(i));
        assign part_word[i] = part_keep[i] ? asm_q[i] : '0;
    end

    // assembly register: captured entry lands in lane cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q <= '0;
        end else if (rd_pend_q) begin
            for (int i = 0; i < PACK; i++) begin
                if (cnt_q == CW'(i)) asm_q[i] <= fifo_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= fifo_rd_en;
            if (load)           cnt_q <= '0;
            else if (rd_pend_q) cnt_q <= cnt_q + 1'b1;
        end
    end

    // flush FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
        end
    end

    // flush FSM: next state
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            FILL: begin
                if (flush) state_d = FLUSH_WAIT;
            end
            FLUSH_WAIT: begin
                // let the in-flight read land and any held full word drain
                if (!rd_pend_q && !cnt_is_full) begin
                    if (cnt_is_zero) begin
                        flush_done_d = 1'b1;
                        state_d      = FILL;
                    end else begin
                        state_d = FLUSH_EMIT;
                    end
                end
            end
            FLUSH_EMIT: begin
                if (slot_free) begin
                    flush_done_d = 1'b1;
                    state_d      = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    stream_out_slot #(
        .WIDTH (WIDTH),
        .PACK  (PACK)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_word),
        .load_keep (load_keep),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .slot_free (slot_free)
    );

    assign flush_done = flush_done_q;
    assign busy       = !cnt_is_zero || rd_pend_q || m_valid || (state_q != FILL);

endmodule

// File: tb/tb_fifo_byte_packer.sv
// tb_fifo_byte_packer
//   Directed bench for fifo_byte_packer (WIDTH=8, PACK=4) behind a 16-deep
//   synchronous FIFO with one-cycle read latency, modelled inline.
module tb_fifo_byte_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_en;
    logic        flush;
    logic        flush_done;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready;
    logic        busy;

    logic        wr_en;
    logic [7:0]  wr_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_byte_packer #(.WIDTH(8), .PACK(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .flush_done (flush_done),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy)
    );

    // ---------------- FIFO model (depth 16) ----------------
    logic [7:0] mem [16];
    logic [3:0] wp, rp;
    logic [4:0] fcnt;
    logic       do_wr, do_rd;

    assign fifo_empty = (fcnt == 5'd0);
    assign do_wr      = wr_en && (fcnt != 5'd16);
    assign do_rd      = fifo_rd_en && (fcnt != 5'd0);

    always @(posedge clk) begin
        if (rst) begin
            wp <= '0; rp <= '0; fcnt <= '0; fifo_dout <= '0;
        end else begin
            if (do_wr) begin mem[wp] <= wr_data; wp <= wp + 4'd1; end
            if (do_rd) begin fifo_dout <= mem[rp]; rp <= rp + 4'd1; end
            fcnt <= fcnt + 5'(do_wr) - 5'(do_rd);
        end
    end

    // ---------------- monitors ----------------
    logic [31:0] beat_data [$];
    logic [3:0]  beat_keep [$];
    int          overread  = 0;
    int          stab_err  = 0;
    int          done_cnt  = 0;
    int          valid_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;

    always @(posedge clk) begin
        if (!rst) begin
            if (fifo_rd_en && fifo_empty) overread++;
            if (m_valid && m_ready) begin
                beat_data.push_back(m_data);
                beat_keep.push_back(m_keep);
            end
            if (prev_stall && (!m_valid || m_data !== prev_data || m_keep !== prev_keep))
                stab_err++;
            if (flush_done) done_cnt++;
            if (m_valid) valid_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_keep  = m_keep;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic wr(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        beat_data.delete();
        beat_keep.delete();
        done_cnt  = 0;
        valid_cnt = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        tests++; if (m_valid !== 1'b0)  begin fails++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        tests++; if (m_data !== 32'h0)  begin fails++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
        tests++; if (m_keep !== 4'h0)   begin fails++; $display("FAIL reset_m_keep got=%h exp=0", m_keep); end
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL reset_flush_done got=%b exp=0", flush_done); end
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    endtask

    task automatic test_single_word();
        clear_mon();
        m_ready = 1'b1;
        wr(8'h11); wr(8'h07); wr(8'h05); wr(8'h64);
        idle(12);
        tests++; if (beat_data.size() != 1) begin fails++; $display("FAIL single_beats got=%0d exp=1", beat_data.size()); end
        if (beat_data.size() >= 1) begin
            tests++; if (beat_data[0] !== 32'h64050711) begin fails++; $display("FAIL single_data got=%h exp=64050711", beat_data[0]); end
            tests++; if (beat_keep[0] !== 4'hF) begin fails++; $display("FAIL single_keep got=%h exp=f", beat_keep[0]); end
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        clear_mon();
        stab_err = 0;
        m_ready  = 1'b0;
        for (int i = 0; i < 8; i++) wr(8'(i));
        idle(12);   // 20 cycles of m_ready=0 in total
        tests++; if (m_valid !== 1'b1 || m_data !== 32'h03020100) begin
            fails++; $display("FAIL bp_held got_valid=%b got_data=%h exp=1/03020100", m_valid, m_data);
        end
        tests++; if (fcnt !== 5'd0) begin fails++; $display("FAIL bp_fifo_level got=%0d exp=0", fcnt); end
        m_ready = 1'b1;
        idle(10);
        tests++; if (beat_data.size() != 2) begin fails++; $display("FAIL bp_beats got=%0d exp=2", beat_data.size()); end
        if (beat_data.size() >= 2) begin
            tests++; if (beat_data[0] !== 32'h03020100) begin fails++; $display("FAIL bp_word0 got=%h exp=03020100", beat_data[0]); end
            tests++; if (beat_data[1] !== 32'h07060504) begin fails++; $display("FAIL bp_word1 got=%h exp=07060504", beat_data[1]); end
        end
        tests++; if (stab_err != 0) begin fails++; $display("FAIL bp_stable got=%0d exp=0", stab_err); end
        tests++; if (overread != 0) begin fails++; $display("FAIL bp_overread got=%0d exp=0", overread); end
    endtask

    task automatic test_flush_partial();
        clear_mon();
        m_ready = 1'b1;
        wr(8'hAA); wr(8'hBB); wr(8'hCC);
        idle(6);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(10);
        tests++; if (beat_data.size() != 1) begin fails++; $display("FAIL flush_beats got=%0d exp=1", beat_data.size()); end
        if (beat_data.size() >= 1) begin
            tests++; if (beat_data[0] !== 32'h00CCBBAA) begin fails++; $display("FAIL flush_data got=%h exp=00ccbbaa", beat_data[0]); end
            tests++; if (beat_keep[0] !== 4'h7) begin fails++; $display("FAIL flush_keep got=%h exp=7", beat_keep[0]); end
        end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL flush_done_pulses got=%0d exp=1", done_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_flush_empty();
        clear_mon();
        flush = 1'b1;
        idle(1);            // edge enters FLUSH_WAIT
        flush = 1'b0;
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL fe_done_early got=%b exp=0", flush_done); end
        idle(1);
        tests++; if (flush_done !== 1'b1) begin fails++; $display("FAIL fe_done got=%b exp=1", flush_done); end
        idle(1);
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL fe_done_width got=%b exp=0", flush_done); end
        idle(4);
        tests++; if (valid_cnt != 0) begin fails++; $display("FAIL fe_no_valid got=%0d exp=0", valid_cnt); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL fe_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_midword();
        m_ready = 1'b1;
        wr(8'h91); wr(8'h92);
        idle(4);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rm_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        tests++; if ({m_valid, m_data, m_keep, flush_done, busy, fifo_rd_en} !== 40'h0) begin
            fails++; $display("FAIL rm_outputs_zero got=%b%h%h%b%b%b exp=0",
                              m_valid, m_data, m_keep, flush_done, busy, fifo_rd_en);
        end
        clear_mon();
        wr(8'h21); wr(8'h22); wr(8'h23); wr(8'h24);
        idle(10);
        tests++; if (beat_data.size() != 1) begin fails++; $display("FAIL rm_beats got=%0d exp=1", beat_data.size()); end
        if (beat_data.size() >= 1) begin
            tests++; if (beat_data[0] !== 32'h24232221) begin fails++; $display("FAIL rm_word got=%h exp=24232221", beat_data[0]); end
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_q [$];
        int         wdone;
        int         guard;
        int         bad;
        clear_mon();
        overread = 0;
        stab_err = 0;
        wdone    = 0;
        for (int i = 0; i < 40; i++) exp_q.push_back(8'($urandom));
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    idle($urandom_range(0, 2));
                    guard = 0;
                    while (fcnt >= 5'd15 && guard < 200) begin idle(1); guard++; end
                    wr(exp_q[i]);
                end
                wdone = 1;
            end
            begin
                while (wdone == 0) begin
                    m_ready = 1'($urandom);
                    idle(1);
                end
            end
        join
        m_ready = 1'b1;
        guard = 0;
        while (beat_data.size() < 10 && guard < 400) begin idle(1); guard++; end
        tests++; if (beat_data.size() != 10) begin fails++; $display("FAIL rnd_beats got=%0d exp=10", beat_data.size()); end
        bad = 0;
        for (int i = 0; i < beat_data.size() && i < 10; i++) begin
            for (int l = 0; l < 4; l++) begin
                if (beat_data[i][l*8 +: 8] !== exp_q[i*4 + l]) bad++;
            end
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL rnd_order got=%0d_bad_bytes exp=0", bad); end
        tests++; if (overread != 0) begin fails++; $display("FAIL rnd_overread got=%0d exp=0", overread); end
        tests++; if (stab_err != 0) begin fails++; $display("FAIL rnd_stable got=%0d exp=0", stab_err); end
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        flush   = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_backpressure();
        test_flush_partial();
        test_flush_empty();
        test_reset_midword();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
